// File: rtl/pmp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmp_ctrl_pkg
// Description : Shared types and constants for the PMP address CSR controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pmp_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BULK = 2'd1,
        DONE = 2'd2
    } pmp_ctrl_state_e;

    localparam int PMP_ADDR_W      = 34;
    localparam int PMP_MAX_REGIONS = 16;
    localparam int PMP_IDX_W       = $clog2(PMP_MAX_REGIONS);

endpackage
`default_nettype wire

// File: rtl/pmp_elock_eval.sv
`default_nettype none
// ============================================================================
// Module      : pmp_elock_eval
// Description : Effective lock per region. A region is locked by its own L
//               bit, or by the next region being a locked TOR region (which
//               uses this region's address as its bottom bound).
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_elock_eval #(
    parameter int NUM_REGIONS = 4
) (
    input  logic [NUM_REGIONS-1:0] lock_i,
    input  logic [NUM_REGIONS-1:0] tor_i,
    output logic [NUM_REGIONS-1:0] elock
);

    genvar i;
    generate
        for (i = 0; i < NUM_REGIONS; i++) begin : g_elock
            if (i + 1 < NUM_REGIONS) begin : g_tor_prop
                assign elock[i] = lock_i[i] | (lock_i[i+1] & tor_i[i+1]);
            end else begin : g_last
                assign elock[i] = lock_i[i];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pmp_addr_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pmp_addr_csr_ctrl
// Description : PMP address register array with a single-beat CSR port and a
//               streaming bulk-load sequencer. Bulk start has priority over
//               CSR in IDLE; writes honour effective (TOR-propagated) locks.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_addr_csr_ctrl
    import pmp_ctrl_pkg::*;
#(
    parameter int PMPNumRegions = 4,
    parameter int PMPAddrWidth  = PMP_ADDR_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    csr_req_i,
    input  logic                    csr_we_i,
    input  logic [PMP_IDX_W-1:0]    csr_idx_i,
    input  logic [PMPAddrWidth-1:0] csr_wdata_i,
    output logic                    csr_gnt_o,
    output logic                    csr_rvalid_o,
    output logic [PMPAddrWidth-1:0] csr_rdata_o,
    output logic                    csr_err_o,
    input  logic [PMPNumRegions-1:0] lock_i,
    input  logic [PMPNumRegions-1:0] tor_i,
    input  logic                    bulk_start_i,
    input  logic                    bulk_valid_i,
    input  logic [PMPAddrWidth-1:0] bulk_data_i,
    output logic                    bulk_ready_o,
    output logic                    bulk_done_o,
    output logic                    bulk_err_o,
    output logic                    busy_o,
    output logic [PMPAddrWidth-1:0] csr_pmp_addr_o [PMPNumRegions]
);

    localparam logic [PMP_IDX_W:0]   c_num_regions = (PMP_IDX_W+1)'(PMPNumRegions);
    localparam logic [PMP_IDX_W-1:0] c_last_idx    = PMP_IDX_W'(PMPNumRegions - 1);

    pmp_ctrl_state_e         r_state;
    logic [PMP_IDX_W-1:0]    r_cnt;
    logic                    r_bulk_err;
    logic                    r_rvalid;
    logic                    r_err;
    logic [PMPAddrWidth-1:0] r_rdata;

    logic [PMPNumRegions-1:0] w_elock;
    logic                     w_gnt;
    logic                     w_idx_ok;
    logic                     w_idx_elock;
    logic                     w_cnt_elock;
    logic [PMPAddrWidth-1:0]  w_rd_mux;
    logic                     w_csr_wr;
    logic                     w_beat;
    logic                     w_bulk_wr;

    pmp_elock_eval #(
        .NUM_REGIONS (PMPNumRegions)
    ) u_elock (
        .lock_i (lock_i),
        .tor_i  (tor_i),
        .elock  (w_elock)
    );

    // Grant only from IDLE, and never when a bulk start claims the same cycle
    assign w_gnt     = csr_req_i && (r_state == IDLE) && !bulk_start_i;
    assign w_idx_ok  = ({1'b0, csr_idx_i} < c_num_regions);
    assign w_csr_wr  = w_gnt && csr_we_i && w_idx_ok && !w_idx_elock;
    assign w_beat    = (r_state == BULK) && bulk_valid_i;
    assign w_bulk_wr = w_beat && !w_cnt_elock;

    // Select lock state and read data for the CSR index and the bulk counter
    always_comb begin
        w_idx_elock = 1'b0;
        w_cnt_elock = 1'b0;
        w_rd_mux    = '0;
        for (int i = 0; i < PMPNumRegions; i++) begin
            if (csr_idx_i == PMP_IDX_W'(i)) begin
                w_idx_elock = w_elock[i];
                w_rd_mux    = csr_pmp_addr_o[i];
            end
            if (r_cnt == PMP_IDX_W'(i)) begin
                w_cnt_elock = w_elock[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PMPNumRegions; gi++) begin : g_region
            logic [PMPAddrWidth-1:0] r_addr;

            // Region register: CSR and bulk writes are mutually exclusive by state
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_addr <= '1;
                end else if (w_csr_wr && (csr_idx_i == PMP_IDX_W'(gi))) begin
                    r_addr <= csr_wdata_i;
                end else if (w_bulk_wr && (r_cnt == PMP_IDX_W'(gi))) begin
                    r_addr <= bulk_data_i;
                end
            end

            assign csr_pmp_addr_o[gi] = r_addr;
        end
    endgenerate

    // Sequencer: IDLE -> BULK (one beat per region) -> DONE -> IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bulk_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bulk_start_i) begin
                        r_state    <= BULK;
                        r_cnt      <= '0;
                        r_bulk_err <= 1'b0;
                    end
                end
                BULK: begin
                    if (bulk_valid_i) begin
                        // A locked beat is consumed but flagged
                        if (w_cnt_elock) begin
                            r_bulk_err <= 1'b1;
                        end
                        if (r_cnt == c_last_idx) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // CSR response, presented the cycle after the grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt && (!w_idx_ok || (csr_we_i && w_idx_elock));
            r_rdata  <= (w_gnt && !csr_we_i && w_idx_ok) ? w_rd_mux : '0;
        end
    end

    assign csr_gnt_o    = w_gnt;
    assign csr_rvalid_o = r_rvalid;
    assign csr_rdata_o  = r_rdata;
    assign csr_err_o    = r_err;
    assign bulk_ready_o = (r_state == BULK);
    assign bulk_done_o  = (r_state == DONE);
    assign bulk_err_o   = r_bulk_err;
    assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/pmp_addr_csr_ctrl.md
# pmp_addr_csr_ctrl

Owns the PMP address register array and drives it as `csr_pmp_addr_o [PMPNumRegions]` toward the PMP checker. The array is written from two sources:
- a single-beat CSR request/grant port, for software accesses to `pmpaddrN`;
- a streaming bulk-load sequencer, for boot/debug restore.

The block arbitrates between the two sources and enforces per-region lock rules, including TOR lock propagation. The result is a registered view of all region addresses.

## Interface
- `PMPNumRegions`, 4, number of regions; legal range 1..16
- `PMPAddrWidth`, 34, width of each region address register
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous assert, active-low
- `csr_req_i`  in  1  CSR access request
- `csr_we_i`  in  1  1 = write, 0 = read
- `csr_idx_i`  in  4  region index (`$clog2(16)`); only the low bits are meaningful
- `csr_wdata_i`  in  `PMPAddrWidth`  write data
- `csr_gnt_o`  out  1  request accepted this cycle
- `csr_rvalid_o`  out  1  response valid, one cycle after grant
- `csr_rdata_o`  out  `PMPAddrWidth`  read data, or 0 on error/write
- `csr_err_o`  out  1  error flag, qualified by `csr_rvalid_o`
- `lock_i`  in  `PMPNumRegions`  `pmpcfg.L` per region
- `tor_i`  in  `PMPNumRegions`  region mode is TOR, per region
- `bulk_start_i`  in  1  start-of-bulk-load pulse
- `bulk_valid_i`  in  1  bulk beat valid
- `bulk_data_i`  in  `PMPAddrWidth`  bulk beat data
- `bulk_ready_o`  out  1  bulk beat accepted when high together with valid
- `bulk_done_o`  out  1  one-cycle pulse after the last beat
- `bulk_err_o`  out  1  sticky: a bulk beat hit a locked region; cleared by the next `bulk_start_i`
- `busy_o`  out  1  FSM not in `IDLE`
- `csr_pmp_addr_o`  out  `[PMPAddrWidth-1:0]` × `PMPNumRegions` (unpacked)  region addresses

## Operation
- Effective lock of region i, `elock[i]`, is `lock_i[i]` OR (`i+1 < PMPNumRegions` AND `lock_i[i+1]` AND `tor_i[i+1]`).
- `elock` is combinational and sampled in the write cycle.
- FSM states:
  - `IDLE`: accepts CSR or bulk start.
  - `BULK`: counter `cnt` runs 0..`PMPNumRegions`-1.
  - `DONE`: one cycle; `bulk_done_o` = 1; then returns to `IDLE`.
- `IDLE` priority: `bulk_start_i` beats `csr_req_i` in the same cycle. In that case `csr_gnt_o` = 0 and the CSR request must be held.
- `IDLE` → `BULK` on `bulk_start_i`:
  - `cnt` = 0
  - `bulk_err_o` cleared
- CSR port:
  - `csr_gnt_o` = `csr_req_i` && state == `IDLE` && !`bulk_start_i`.
  - CSR write with an in-range index and `!elock`: the register is updated on the grant edge.
  - CSR write with an out-of-range index (`csr_idx_i` ≥ `PMPNumRegions`) or with `elock` set: the array is unchanged and `csr_err_o` = 1 in the response.
  - CSR read with an out-of-range index: `csr_rdata_o` = 0 and `csr_err_o` = 1.
- `BULK`:
  - `bulk_ready_o` = 1.
  - Each accepted beat writes region `cnt` unless `elock[cnt]`; a locked beat is still consumed but sets `bulk_err_o`.
  - The beat at `cnt == PMPNumRegions-1` moves the FSM to `DONE`.
  - `bulk_valid_i` low stalls the sequence indefinitely; there is no timeout.
- `bulk_start_i` outside `IDLE` is ignored.
- `csr_req_i` while not in `IDLE`: `csr_gnt_o` stays 0.

## Timing
- Reset values:
  - all `csr_pmp_addr_o[i]` = all ones (`'1`)
  - state = `IDLE`, `cnt` = 0
  - `csr_gnt_o`, `csr_rvalid_o`, `csr_err_o`, `bulk_ready_o`, `bulk_done_o`, `bulk_err_o`, `busy_o` = 0
  - `csr_rdata_o` = 0
- CSR latency:
  - grant is combinational in cycle T;
  - `csr_rvalid_o`, `csr_rdata_o` and `csr_err_o` are registered and valid in T+1 only;
  - a write is visible on `csr_pmp_addr_o` in T+1;
  - back-to-back grants are allowed, one per cycle.
- A read granted in the cycle after a write to the same index returns the new value.
- Bulk throughput: one beat per cycle. `N` regions take `N` beat cycles, then one `DONE` cycle; `busy_o` is high in `BULK` and `DONE`.
- Asynchronous reset mid-bulk: the array returns to `'1`, the FSM to `IDLE`, and the partial load is discarded.
- A `lock_i` change between beats takes effect on the next beat.

## Structure
- Package `pmp_ctrl_pkg` holds:
  - `pmp_ctrl_state_e` (`IDLE`, `BULK`, `DONE`)
  - `PMP_ADDR_W` = 34
  - `PMP_MAX_REGIONS` = 16
- Sub-module `pmp_elock_eval`: combinational; inputs `lock_i` and `tor_i`; output `elock`.
- Register array, counter and FSM live in the top module. The array is reset via a generate loop over regions.

## Test plan
- Reset release → all four `csr_pmp_addr_o[0..3]` = `34'h3_FFFF_FFFF`; every control output = 0.
- CSR write idx 2 with `34'h0_1234_5678` → `gnt` = 1 the same cycle; T+1: `rvalid` = 1, `err` = 0, `csr_pmp_addr_o[2]` = `34'h0_1234_5678`. A read of idx 2 in T+1 → `rdata` = `34'h0_1234_5678` in T+2.
- `lock_i` = `4'b1000`, `tor_i` = `4'b1000`; CSR write idx 2 → `err` = 1 and region 2 unchanged. Write idx 1 → succeeds. Read idx 5 → `err` = 1, `rdata` = 0.
- `bulk_start_i` and `csr_req_i` in the same cycle → `gnt` = 0. Four beats `34'h10`..`34'h13` with one valid-low bubble → regions = `34'h10`..`34'h13`; `bulk_done_o` pulses one cycle after the last beat. The held CSR request is granted in the cycle after `DONE`.
- Bulk with `lock_i[1]` = 1 → region 1 keeps its old value, the other regions load, `bulk_err_o` = 1 until the next `bulk_start_i`.
- Assert `rst_ni` after two bulk beats → outputs immediately `'1`, `busy_o` = 0; a subsequent full bulk load completes normally.
